// File: rtl/user_io_pkg.sv
// Shared definitions for the user input conditioner: mode encodings and
// the step FSM state type.
`timescale 1ns/1ps
package user_io_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_SLOW       = 2'b00;
  localparam mode_t MODE_FAST       = 2'b10;
  localparam mode_t MODE_FASTEST    = 2'b11;
  localparam mode_t MODE_SINGLESTEP = 2'b01;

  typedef enum logic [1:0] {
    IDLE         = 2'b00,
    PULSE        = 2'b01,
    WAIT_RELEASE = 2'b10
  } step_state_t;

endpackage

// File: rtl/debounce_filter.sv
// One-bit conditioner: 2-flop synchronizer, stability counter and accepted
// (stable) value. 'accept' is high the cycle before 'stable' takes a new value.
`timescale 1ns/1ps
module debounce_filter #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter logic        RESET_LEVEL     = 1'b0
) (
  input  logic source_clock,
  input  logic reset_n,
  input  logic raw,
  output logic stable,
  output logic settled,
  output logic accept
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  assign settled = (sync2 == stable);
  assign accept  = !settled && (cnt == LAST);

  always_ff @(posedge source_clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1  <= RESET_LEVEL;
      sync2  <= RESET_LEVEL;
      stable <= RESET_LEVEL;
      cnt    <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (settled) begin
        cnt <= '0;
      end else if (accept) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/user_input_conditioner.sv
// Conditions the step pushbutton and mode switches: debounced mode with a
// change strobe, and one fixed-width step pulse per press in single-step mode.
`timescale 1ns/1ps
module user_input_conditioner
  import user_io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = 500000,
  parameter int unsigned STEP_PULSE_CYCLES = 25000,
  parameter bit          BUTTON_ACTIVE_LOW = 1'b1
) (
  input  logic       source_clock,
  input  logic       reset_n,
  input  logic       raw_step,
  input  logic [1:0] raw_mode,
  output logic       step,
  output logic [1:0] mode,
  output logic       mode_changed,
  output logic [7:0] step_count
);

  localparam logic STEP_RELEASED = BUTTON_ACTIVE_LOW;
  localparam int unsigned PW = (STEP_PULSE_CYCLES > 1) ? $clog2(STEP_PULSE_CYCLES) : 1;
  localparam logic [PW-1:0] PULSE_LAST = PW'(STEP_PULSE_CYCLES - 1);

  logic          step_stable;
  logic          step_settled;
  logic          step_accept;
  logic [1:0]    mode_settled;
  logic [1:0]    mode_accept;
  logic          pressed;
  logic          pressed_d;
  logic          press_edge;
  logic          armed;
  logic [1:0]    settle_cnt;
  logic [PW-1:0] pulse_cnt;
  step_state_t   state;

  debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_LEVEL(STEP_RELEASED)) u_step_filter (
    .source_clock (source_clock),
    .reset_n      (reset_n),
    .raw          (raw_step),
    .stable       (step_stable),
    .settled      (step_settled),
    .accept       (step_accept)
  );

  // The stable flops of the mode filters are the registered mode output.
  debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_LEVEL(1'b0)) u_mode0_filter (
    .source_clock (source_clock),
    .reset_n      (reset_n),
    .raw          (raw_mode[0]),
    .stable       (mode[0]),
    .settled      (mode_settled[0]),
    .accept       (mode_accept[0])
  );

  debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_LEVEL(1'b0)) u_mode1_filter (
    .source_clock (source_clock),
    .reset_n      (reset_n),
    .raw          (raw_mode[1]),
    .stable       (mode[1]),
    .settled      (mode_settled[1]),
    .accept       (mode_accept[1])
  );

  assign pressed    = step_stable ^ BUTTON_ACTIVE_LOW;
  assign press_edge = pressed && !pressed_d;

  always_ff @(posedge source_clock or negedge reset_n) begin
    if (!reset_n) begin
      mode_changed <= 1'b0;
    end else begin
      mode_changed <= |mode_accept;
    end
  end

  // Presses are ignored until, after the synchronizers have flushed, all
  // inputs are quiet with the button released: a button held through reset
  // must be let go before it can step.
  always_ff @(posedge source_clock or negedge reset_n) begin
    if (!reset_n) begin
      pressed_d  <= 1'b0;
      settle_cnt <= '0;
      armed      <= 1'b0;
    end else begin
      pressed_d <= pressed;
      if (settle_cnt != 2'd2) begin
        settle_cnt <= settle_cnt + 2'd1;
      end else if (step_settled && (&mode_settled) && !step_accept && !pressed) begin
        armed <= 1'b1;
      end
    end
  end

  always_ff @(posedge source_clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      step       <= 1'b0;
      step_count <= '0;
      pulse_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (press_edge && armed) begin
            if (mode == MODE_SINGLESTEP) begin
              state      <= PULSE;
              step       <= 1'b1;
              step_count <= step_count + 8'd1;
              pulse_cnt  <= '0;
            end else begin
              state <= WAIT_RELEASE;
            end
          end
        end
        PULSE: begin
          if (pulse_cnt == PULSE_LAST) begin
            step      <= 1'b0;
            pulse_cnt <= '0;
            state     <= pressed ? WAIT_RELEASE : IDLE;
          end else begin
            pulse_cnt <= pulse_cnt + PW'(1);
          end
        end
        WAIT_RELEASE: begin
          if (!pressed) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_user_input_conditioner.sv
// Directed bench for user_input_conditioner with short debounce/pulse settings.
`timescale 1ns/1ps
module tb_user_input_conditioner;

  logic       source_clock = 1'b0;
  logic       reset_n;
  logic       raw_step;
  logic [1:0] raw_mode;
  logic       step;
  logic [1:0] mode;
  logic       mode_changed;
  logic [7:0] step_count;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int          hi;
  int          st;

  user_input_conditioner #(
    .DEBOUNCE_CYCLES   (4),
    .STEP_PULSE_CYCLES (3),
    .BUTTON_ACTIVE_LOW (1'b1)
  ) dut (
    .source_clock (source_clock),
    .reset_n      (reset_n),
    .raw_step     (raw_step),
    .raw_mode     (raw_mode),
    .step         (step),
    .mode         (mode),
    .mode_changed (mode_changed),
    .step_count   (step_count)
  );

  always #5 source_clock = ~source_clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge source_clock);
      #1;
    end
  endtask

  // Button low for 'hold' cycles then high for 'gap'; counts step-high cycles and strobes.
  task automatic press(input int hold, input int gap, output int hi_cycles, output int strobes);
    hi_cycles = 0;
    strobes   = 0;
    raw_step  = 1'b0;
    for (int k = 0; k < hold + gap; k++) begin
      if (k == hold) raw_step = 1'b1;
      tick(1);
      if (step) hi_cycles++;
      if (mode_changed) strobes++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset_n  = 1'b0;
    raw_step = 1'b1;
    raw_mode = 2'b00;
    tick(3);
    check("rst_step", step, 0);
    check("rst_mode", mode, 0);
    check("rst_mode_changed", mode_changed, 0);
    check("rst_count", step_count, 0);
    reset_n = 1'b1;
    tick(5);

    // Slow mode: press is absorbed, no pulse
    press(15, 12, hi, st);
    check("slow_no_pulse", hi, 0);
    check("slow_count", step_count, 0);

    // Mode debounce: new value and one strobe 6 cycles after the switch moves
    raw_mode = 2'b01;
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      check("mode_latency", mode, (k >= 6) ? 2'b01 : 2'b00);
      check("mode_strobe", mode_changed, (k == 6) ? 1 : 0);
    end
    tick(4);

    // Single step: pulse on cycles 7..9 after the press
    raw_step = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      check("step_timing", step, (k >= 7 && k <= 9) ? 1 : 0);
      check("count_timing", step_count, (k >= 7) ? 1 : 0);
    end
    raw_step = 1'b1;
    tick(12);

    // Glitch shorter than the debounce window
    raw_step = 1'b0;
    tick(2);
    raw_step = 1'b1;
    hi = 0;
    for (int k = 0; k < 12; k++) begin
      tick(1);
      if (step) hi++;
    end
    check("glitch_no_pulse", hi, 0);
    check("glitch_count", step_count, 1);

    // Long hold gives one pulse; next press gives another
    press(100, 12, hi, st);
    check("long_hold_width", hi, 3);
    check("long_hold_count", step_count, 2);
    press(20, 12, hi, st);
    check("second_press_width", hi, 3);
    check("second_press_count", step_count, 3);

    // Both mode bits flip while the pulse is in flight
    hi = 0;
    st = 0;
    raw_step = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (k == 3) raw_mode = 2'b10;
      if (k == 20) raw_step = 1'b1;
      tick(1);
      if (step) hi++;
      if (mode_changed) st++;
    end
    check("mode_mid_pulse_width", hi, 3);
    check("mode_both_bits_strobes", st, 1);
    check("mode_mid_pulse_mode", mode, 2'b10);
    check("mode_mid_pulse_count", step_count, 4);
    raw_mode = 2'b01;
    tick(10);
    check("mode_back_single", mode, 2'b01);

    // Reset during the pulse, button held throughout
    raw_step = 1'b0;
    tick(8);
    check("pre_reset_step", step, 1);
    reset_n = 1'b0;
    #1;
    check("reset_async_step", step, 0);
    check("reset_async_count", step_count, 0);
    tick(3);
    reset_n = 1'b1;
    hi = 0;
    for (int k = 0; k < 30; k++) begin
      tick(1);
      if (step) hi++;
    end
    check("held_through_reset", hi, 0);
    check("held_through_reset_count", step_count, 0);
    raw_step = 1'b1;
    tick(12);
    press(20, 12, hi, st);
    check("after_reset_press", hi, 3);
    check("after_reset_count", step_count, 1);

    // Wrap-around of the step counter
    for (int i = 0; i < 254; i++) press(8, 10, hi, st);
    check("count_255", step_count, 255);
    press(8, 10, hi, st);
    check("count_wrap", step_count, 0);
    check("wrap_pulse_width", hi, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
